cr_prefix_pfq: RTL and testbench

- Prefix-number queue: buffers per-frame prefix results from the prefix match engine and presents them to the prefix output controller as a first-word-fall-through stream of 9-bit entries.
- Each entry carries either a prefix number (0 means no prefix) or an error flag plus an 8-bit zipline error code.
- Sits directly upstream of the output controller. It drives `pf_data`/`pf_empty`/`pf_aempty` and consumes `pf_ren`.
- Also provides sticky underflow detection, a high-water mark and an error-entry counter for debug.

---
 rtl/cr_prefix_pfq_pkg.sv | 47 ++++
 rtl/cr_prefix_pfq_if.sv | 35 +++
 rtl/cr_prefix_pfq_fifo.sv | 82 ++++++++
 rtl/cr_prefix_pfq.sv | 110 +++++++++++
 tb/tb_cr_prefix_pfq.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cr_prefix_pfq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cr_prefixPKG
// Purpose  : Shared types and constants for the prefix-number queue.
//            pf_entry_t is the 9-bit queue entry: an error flag plus an
//            8-bit payload that holds either a zipline error code or a
//            zero-extended 6-bit prefix number.
// Revision : 1.0 - initial release
// ============================================================================
package cr_prefixPKG;

    localparam int PFQ_ERR_CNT_W = 16;
    localparam int PF_ENTRY_W    = 9;

    typedef struct packed {
        logic [1:0] rsvd;
        logic [5:0] prefix_num;
    } pf_pfx_t;

    // Error code and prefix number share the same 8 payload bits.
    typedef union packed {
        logic [7:0] code;
        pf_pfx_t    pfx;
    } pf_payload_t;

    typedef struct packed {
        logic        err;
        pf_payload_t payload;
    } pf_entry_t;

    // Build a queue entry from a match-engine result.
    function automatic pf_entry_t pf_encode(input logic       err,
                                            input logic [7:0] code,
                                            input logic [5:0] prefix_num);
        pf_entry_t e;
        e.err = err;
        if (err) begin
            e.payload.code = code;
        end else begin
            e.payload.pfx.rsvd       = 2'b00;
            e.payload.pfx.prefix_num = prefix_num;
        end
        return e;
    endfunction

endpackage : cr_prefixPKG
`default_nettype wire

// File: rtl/cr_prefix_pfq_if.sv
`default_nettype none
// ============================================================================
// Module   : cr_prefix_pfq_if
// Purpose  : Result-in / prefix-out channel bundle of the prefix queue.
//            master : the environment (match engine + output controller)
//            slave  : the queue itself
// Signals  : res_valid/res_ready/res_error/res_err_code/res_prefix_num
//            pf_data/pf_empty/pf_aempty/pf_ren
// Revision : 1.0 - initial release
// ============================================================================
interface cr_prefix_pfq_if;
    import cr_prefixPKG::*;

    logic                  res_valid;
    logic                  res_ready;
    logic                  res_error;
    logic [7:0]            res_err_code;
    logic [5:0]            res_prefix_num;
    logic [PF_ENTRY_W-1:0] pf_data;
    logic                  pf_empty;
    logic                  pf_aempty;
    logic                  pf_ren;

    modport master (
        output res_valid, res_error, res_err_code, res_prefix_num, pf_ren,
        input  res_ready, pf_data, pf_empty, pf_aempty
    );

    modport slave (
        input  res_valid, res_error, res_err_code, res_prefix_num, pf_ren,
        output res_ready, pf_data, pf_empty, pf_aempty
    );

endinterface : cr_prefix_pfq_if
`default_nettype wire

// File: rtl/cr_prefix_pfq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cr_prefix_pfq_fifo
// Purpose  : Parameterised first-word-fall-through FIFO. Pointers carry one
//            extra MSB so full and empty are distinguished without a
//            separate counter. Flush zeroes both pointers and discards any
//            same-cycle write or read.
// Ports    : clk, rst_n        clock, async active-low reset
//            wr_en_i/wr_data_i write request (ignored when full)
//            rd_en_i           pop request (ignored when empty)
//            flush_i           synchronous flush
//            rd_data_o         head entry, 0 when empty
//            empty_o/full_o    status from registered pointers
//            count_o           current occupancy
//            count_nxt_o       occupancy after this edge
// Revision : 1.0 - initial release
// ============================================================================
module cr_prefix_pfq_fifo #(
    parameter int DEPTH = 8,      // power of two, >= 2
    parameter int WIDTH = 9
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       wr_en_i,
    input  wire logic [WIDTH-1:0]           wr_data_i,
    input  wire logic                       rd_en_i,
    input  wire logic                       flush_i,
    output logic      [WIDTH-1:0]           rd_data_o,
    output logic                            empty_o,
    output logic                            full_o,
    output logic      [$clog2(DEPTH):0]     count_o,
    output logic      [$clog2(DEPTH):0]     count_nxt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_fire;
    logic             rd_fire;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (count_o == '0);
    assign full_o  = (count_o == FULL_CNT);

    assign wr_fire = wr_en_i & ~full_o  & ~flush_i;
    assign rd_fire = rd_en_i & ~empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_fire};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_fire};
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    assign count_nxt_o = wr_ptr_d - rd_ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; stale contents are masked by empty_o.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule : cr_prefix_pfq_fifo
`default_nettype wire

// File: rtl/cr_prefix_pfq.sv
`default_nettype none
// ============================================================================
// Module   : cr_prefix_pfq
// Purpose  : Prefix-number queue between the prefix match engine and the
//            prefix output controller. Encodes each result into a 9-bit
//            entry, buffers it in an FWFT FIFO and keeps sticky/debug state.
// Ports    : clk, rst_n    clock, async active-low reset
//            pf_if         result input and pf_* output channel (slave)
//            pfq_flush     drop queued entries (next cycle empty)
//            pfq_clr       clear uflow/err_cnt, reload hwm
//            pfq_uflow     sticky: pop seen while empty
//            pfq_hwm       maximum occupancy since reset/clear
//            pfq_err_cnt   saturating count of accepted error entries
// Revision : 1.0 - initial release
// ============================================================================
module cr_prefix_pfq
    import cr_prefixPKG::*;
#(
    parameter int DEPTH      = 8,     // power of two, >= 2
    parameter int AEMPTY_LVL = 1
) (
    input  wire logic                        clk,
    input  wire logic                        rst_n,
    cr_prefix_pfq_if.slave                   pf_if,
    input  wire logic                        pfq_flush,
    input  wire logic                        pfq_clr,
    output logic                             pfq_uflow,
    output logic      [$clog2(DEPTH):0]      pfq_hwm,
    output logic      [PFQ_ERR_CNT_W-1:0]    pfq_err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AEMPTY_THR = (AW+1)'(AEMPTY_LVL);

    pf_entry_t                w_entry;
    logic                     w_full;
    logic                     w_empty;
    logic [AW:0]              w_count;
    logic [AW:0]              w_count_nxt;
    logic                     w_err_wr;

    logic                     uflow_q, uflow_d;
    logic [AW:0]              hwm_q, hwm_d;
    logic [PFQ_ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign w_entry = pf_encode(pf_if.res_error, pf_if.res_err_code,
                               pf_if.res_prefix_num);

    cr_prefix_pfq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PF_ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (pf_if.res_valid),
        .wr_data_i   (w_entry),
        .rd_en_i     (pf_if.pf_ren),
        .flush_i     (pfq_flush),
        .rd_data_o   (pf_if.pf_data),
        .empty_o     (w_empty),
        .full_o      (w_full),
        .count_o     (w_count),
        .count_nxt_o (w_count_nxt)
    );

    // Ready depends only on registered occupancy: a pop at full does not
    // open the queue until the following cycle.
    assign pf_if.res_ready = ~w_full;
    assign pf_if.pf_empty  = w_empty;
    assign pf_if.pf_aempty = (w_count <= AEMPTY_THR);

    // An error write counts only if it actually lands in the FIFO.
    assign w_err_wr = pf_if.res_valid & ~w_full & ~pfq_flush & pf_if.res_error;

    always_comb begin
        uflow_d   = uflow_q | (pf_if.pf_ren & w_empty);
        err_cnt_d = err_cnt_q;
        if (w_err_wr && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
        hwm_d = (w_count_nxt > hwm_q) ? w_count_nxt : hwm_q;

        // Clear takes priority: same-cycle events are intentionally lost.
        // The high-water mark restarts from the pre-edge occupancy, or from
        // zero when the queue is being flushed at the same time.
        if (pfq_clr) begin
            uflow_d   = 1'b0;
            err_cnt_d = '0;
            hwm_d     = pfq_flush ? '0 : w_count;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uflow_q   <= 1'b0;
            hwm_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            uflow_q   <= uflow_d;
            hwm_q     <= hwm_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pfq_uflow   = uflow_q;
    assign pfq_hwm     = hwm_q;
    assign pfq_err_cnt = err_cnt_q;

endmodule : cr_prefix_pfq
`default_nettype wire

// File: tb/tb_cr_prefix_pfq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cr_prefix_pfq
// Purpose  : Directed, self-checking bench for cr_prefix_pfq (DEPTH=8,
//            AEMPTY_LVL=1): a vector table for single-cycle behaviour plus
//            hand-written fill, streaming and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cr_prefix_pfq;

    logic        clk;
    logic        rst_n;
    logic        pfq_flush;
    logic        pfq_clr;
    logic        pfq_uflow;
    logic [3:0]  pfq_hwm;
    logic [15:0] pfq_err_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    cr_prefix_pfq_if intf ();

    cr_prefix_pfq #(
        .DEPTH      (8),
        .AEMPTY_LVL (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pf_if       (intf.slave),
        .pfq_flush   (pfq_flush),
        .pfq_clr     (pfq_clr),
        .pfq_uflow   (pfq_uflow),
        .pfq_hwm     (pfq_hwm),
        .pfq_err_cnt (pfq_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        err;
        logic [7:0]  code;
        logic [5:0]  pnum;
        logic        ren;
        logic        flush;
        logic        clr;
        logic [8:0]  e_data;
        logic        e_empty;
        logic        e_aempty;
        logic        e_ready;
        logic        e_uflow;
        logic [3:0]  e_hwm;
        logic [15:0] e_err;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic v, input logic er, input logic [7:0] cd,
                                input logic [5:0] pn, input logic rn, input logic fl,
                                input logic cl, input logic [8:0] d, input logic em,
                                input logic ae, input logic rd, input logic uf,
                                input logic [3:0] hw, input logic [15:0] ec);
        vec_t t;
        t.valid = v;  t.err = er; t.code = cd; t.pnum = pn; t.ren = rn;
        t.flush = fl; t.clr = cl; t.e_data = d; t.e_empty = em; t.e_aempty = ae;
        t.e_ready = rd; t.e_uflow = uf; t.e_hwm = hw; t.e_err = ec;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [8:0] d, input logic em,
                           input logic ae, input logic rd, input logic uf,
                           input logic [3:0] hw, input logic [15:0] ec);
        chk({tag, ".pf_data"},   32'(intf.pf_data),   32'(d));
        chk({tag, ".pf_empty"},  32'(intf.pf_empty),  32'(em));
        chk({tag, ".pf_aempty"}, 32'(intf.pf_aempty), 32'(ae));
        chk({tag, ".res_ready"}, 32'(intf.res_ready), 32'(rd));
        chk({tag, ".uflow"},     32'(pfq_uflow),      32'(uf));
        chk({tag, ".hwm"},       32'(pfq_hwm),        32'(hw));
        chk({tag, ".err_cnt"},   32'(pfq_err_cnt),    32'(ec));
    endtask

    task automatic drive(input logic v, input logic er, input logic [7:0] cd,
                         input logic [5:0] pn, input logic rn, input logic fl,
                         input logic cl);
        intf.res_valid      = v;
        intf.res_error      = er;
        intf.res_err_code   = cd;
        intf.res_prefix_num = pn;
        intf.pf_ren         = rn;
        pfq_flush           = fl;
        pfq_clr             = cl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model of queue contents for the hand-written sequences.
    logic [8:0] mq [$];

    function automatic logic [8:0] head();
        return (mq.size() == 0) ? 9'h000 : mq[0];
    endfunction

    initial begin
        // ---------------- vector table ----------------
        //          v  er code   pnum  ren fl cl  data    em ae rd uf hwm err
        tbl[0]  = mk(0, 0, 8'h00, 6'h00, 0, 0, 0, 9'h000, 1, 1, 1, 0, 0, 0);
        tbl[1]  = mk(1, 0, 8'h00, 6'h05, 0, 0, 0, 9'h005, 0, 1, 1, 0, 1, 0);
        tbl[2]  = mk(0, 0, 8'h00, 6'h00, 1, 0, 0, 9'h000, 1, 1, 1, 0, 1, 0);
        tbl[3]  = mk(1, 1, 8'h2A, 6'h11, 0, 0, 0, 9'h12A, 0, 1, 1, 0, 1, 1);
        tbl[4]  = mk(1, 0, 8'hFF, 6'h07, 0, 0, 0, 9'h12A, 0, 0, 1, 0, 2, 1);
        tbl[5]  = mk(1, 1, 8'h55, 6'h00, 1, 0, 0, 9'h007, 0, 0, 1, 0, 2, 2);
        tbl[6]  = mk(0, 0, 8'h00, 6'h00, 1, 0, 0, 9'h155, 0, 1, 1, 0, 2, 2);
        tbl[7]  = mk(0, 0, 8'h00, 6'h00, 1, 0, 0, 9'h000, 1, 1, 1, 0, 2, 2);
        tbl[8]  = mk(0, 0, 8'h00, 6'h00, 1, 0, 0, 9'h000, 1, 1, 1, 1, 2, 2);
        tbl[9]  = mk(0, 0, 8'h00, 6'h00, 0, 0, 0, 9'h000, 1, 1, 1, 1, 2, 2);
        tbl[10] = mk(0, 0, 8'h00, 6'h00, 0, 0, 1, 9'h000, 1, 1, 1, 0, 0, 0);
        tbl[11] = mk(1, 0, 8'h00, 6'h3F, 0, 0, 0, 9'h03F, 0, 1, 1, 0, 1, 0);
        tbl[12] = mk(1, 0, 8'h00, 6'h01, 0, 0, 0, 9'h03F, 0, 0, 1, 0, 2, 0);
        tbl[13] = mk(1, 0, 8'h00, 6'h02, 0, 0, 0, 9'h03F, 0, 0, 1, 0, 3, 0);
        tbl[14] = mk(1, 0, 8'h00, 6'h03, 0, 0, 0, 9'h03F, 0, 0, 1, 0, 4, 0);
        tbl[15] = mk(1, 1, 8'h99, 6'h00, 1, 1, 0, 9'h000, 1, 1, 1, 0, 4, 0);
        tbl[16] = mk(0, 0, 8'h00, 6'h00, 1, 0, 0, 9'h000, 1, 1, 1, 1, 4, 0);
        tbl[17] = mk(0, 0, 8'h00, 6'h00, 0, 1, 1, 9'h000, 1, 1, 1, 0, 0, 0);
        tbl[18] = mk(1, 0, 8'h00, 6'h01, 0, 0, 0, 9'h001, 0, 1, 1, 0, 1, 0);
        tbl[19] = mk(1, 0, 8'h00, 6'h02, 0, 0, 0, 9'h001, 0, 0, 1, 0, 2, 0);
        tbl[20] = mk(0, 0, 8'h00, 6'h00, 1, 0, 1, 9'h002, 0, 1, 1, 0, 2, 0);
        tbl[21] = mk(0, 0, 8'h00, 6'h00, 1, 0, 0, 9'h000, 1, 1, 1, 0, 2, 0);

        // ---------------- reset ----------------
        drive(0, 0, 8'h00, 6'h00, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 9'h000, 1, 1, 1, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].valid, tbl[i].err, tbl[i].code, tbl[i].pnum,
                  tbl[i].ren, tbl[i].flush, tbl[i].clr);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_empty,
                    tbl[i].e_aempty, tbl[i].e_ready, tbl[i].e_uflow,
                    tbl[i].e_hwm, tbl[i].e_err);
        end
        drive(0, 0, 8'h00, 6'h00, 0, 0, 0);

        // ---------------- fill to DEPTH, backpressure, pop at full --------
        mq.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 8'h00, 6'(8'h10 + i), 0, 0, 0);
            step();
            mq.push_back(9'(8'h10 + i));
            chk(
                $sformatf("fill%0d.ready", i), 32'(intf.res_ready), 32'(i < 7));
            chk($sformatf("fill%0d.data", i), 32'(intf.pf_data), 32'(head()));
            chk($sformatf("fill%0d.hwm", i), 32'(pfq_hwm), (i + 1 > 2) ? 32'(i + 1) : 32'd2);
        end
        // Ninth write held off.
        drive(1, 0, 8'h00, 6'h3E, 0, 0, 0);
        step();
        chk("full_hold.ready", 32'(intf.res_ready), 32'd0);
        chk("full_hold.empty", 32'(intf.pf_empty), 32'd0);
        chk("full_hold.hwm", 32'(pfq_hwm), 32'd8);
        // Pop at full with a write pending: ready stays low this cycle.
        drive(1, 0, 8'h00, 6'h3E, 1, 0, 0);
        chk("full_pop.ready_same", 32'(intf.res_ready), 32'd0);
        step();
        void'(mq.pop_front());
        chk("full_pop.ready_next", 32'(intf.res_ready), 32'd1);
        chk("full_pop.data", 32'(intf.pf_data), 32'(head()));
        // Drain; the held-off 0x3E must never appear.
        drive(0, 0, 8'h00, 6'h00, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step();
            void'(mq.pop_front());
            chk($sformatf("drain%0d.data", i), 32'(intf.pf_data), 32'(head()));
            chk($sformatf("drain%0d.empty", i), 32'(intf.pf_empty), 32'(mq.size() == 0));
        end

        // ---------------- streaming at occupancy 3 ----------------
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 8'h00, 6'(8'h20 + i), 0, 0, 0);
            step();
            mq.push_back(9'(8'h20 + i));
        end
        chk("stream_pre.data", 32'(intf.pf_data), 32'h020);
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 8'h00, 6'(8'h23 + i), 1, 0, 0);
            step();
            void'(mq.pop_front());
            mq.push_back(9'(8'h23 + i));
            chk($sformatf("stream%0d.data", i), 32'(intf.pf_data), 32'(head()));
            chk($sformatf("stream%0d.aempty", i), 32'(intf.pf_aempty), 32'd0);
            chk($sformatf("stream%0d.ready", i), 32'(intf.res_ready), 32'd1);
        end
        drive(0, 0, 8'h00, 6'h00, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            void'(mq.pop_front());
            chk($sformatf("sdrain%0d.data", i), 32'(intf.pf_data), 32'(head()));
        end
        chk("sdrain.empty", 32'(intf.pf_empty), 32'd1);
        chk("sdrain.uflow", 32'(pfq_uflow), 32'd0);

        // ---------------- reset mid-operation ----------------
        drive(1, 1, 8'h77, 6'h00, 0, 0, 0);
        step();
        step();
        chk("prerst.errcnt", 32'(pfq_err_cnt), 32'd2);
        drive(0, 0, 8'h00, 6'h00, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("midrst", 9'h000, 1, 1, 1, 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();
        chk_all("postrst", 9'h000, 1, 1, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_cr_prefix_pfq
`default_nettype wire
